// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port plus decode port.
// inst_adel is present only when FETCH_ADEL_EN is defined.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
`ifdef FETCH_ADEL_EN
    logic        inst_adel;
`endif

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output inst,
        output inst_pc,
        output inst_valid,
`ifdef FETCH_ADEL_EN
        output inst_adel,
`endif
        input  inst_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  inst,
        input  inst_pc,
        input  inst_valid,
`ifdef FETCH_ADEL_EN
        input  inst_adel,
`endif
        output inst_ready
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, req/ack fetch, small FIFO to decode.
// FETCH_ADEL_EN adds inst_adel and misaligned-PC fault entries.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    if_fetch_if.master  bus,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
`ifdef FETCH_ADEL_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q;
    logic          req_q;
    logic          halt_q, halt_d;
    logic [31:0]   redir_pc;

    logic [31:0]   mem_pc   [BUF_DEPTH];
    logic [31:0]   mem_data [BUF_DEPTH];
    logic          mem_adel [BUF_DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_pop;

    logic          push, pop, flush;
    logic [31:0]   push_pc, push_data;
    logic          push_adel;
    logic [31:0]   head_pc, head_data;
    logic          head_adel;

    logic [31:0]   inst_q, inst_pc_q;
    logic          valid_q, adel_q;

    function automatic logic misal(input logic [1:0] lo);
        return ADEL_EN && (lo != 2'b00);
    endfunction

    assign redir_pc = ADEL_EN ? redirect_pc
                              : {redirect_pc[31:2], 2'b00};

    // Fetch control: next state, next pc, FIFO push and flush
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        halt_d    = halt_q;
        push      = 1'b0;
        push_pc   = pc_q;
        push_data = bus.imem_rdata;
        push_adel = 1'b0;
        flush     = 1'b0;
        pop       = valid_q && bus.inst_ready;
        cnt_pop   = cnt_q - CW'(pop);

        unique case (state_q)
            IDLE: begin
                if (!halt_q && cnt_pop < DEPTH) begin
                    if (misal(pc_q[1:0])) begin
                        push      = 1'b1;
                        push_data = '0;
                        push_adel = 1'b1;
                        halt_d    = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (cnt_pop + CW'(1) < DEPTH)
                        state_d = REQ;
                    else
                        state_d = IDLE;
                end
            end
            DROP: begin
                if (bus.imem_ack)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // Redirect wins over push and pop; an unanswered
        // request must still be retired, hence DROP
        if (redirect) begin
            flush  = 1'b1;
            push   = 1'b0;
            pc_d   = redir_pc;
            halt_d = 1'b0;
            if (state_q != IDLE && !bus.imem_ack)
                state_d = DROP;
            else
                state_d = REQ;
        end

        // Never request a misaligned address
        if (state_d == REQ && misal(pc_d[1:0]))
            state_d = IDLE;
    end

    // FIFO next count/read pointer and the entry that becomes head
    always_comb begin
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        if (push && wr_q == rd_d) begin
            head_pc   = push_pc;
            head_data = push_data;
            head_adel = push_adel;
        end else begin
            head_pc   = mem_pc[rd_d];
            head_data = mem_data[rd_d];
            head_adel = mem_adel[rd_d];
        end
    end

    // State, pc and registered memory request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            req_q   <= (state_d != IDLE);
            if (state_d != DROP)
                addr_q <= pc_d;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_data[i] <= '0;
                mem_adel[i] <= 1'b0;
            end
        end else begin
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (flush)
                wr_q <= '0;
            else if (push)
                wr_q <= wr_q + AW'(1);
            if (push) begin
                mem_pc[wr_q]   <= push_pc;
                mem_data[wr_q] <= push_data;
                mem_adel[wr_q] <= push_adel;
            end
        end
    end

    // Decode-side outputs: registered head, zero when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            adel_q    <= 1'b0;
        end else begin
            valid_q   <= (cnt_d != '0);
            inst_q    <= (cnt_d != '0) ? head_data : '0;
            inst_pc_q <= (cnt_d != '0) ? head_pc : '0;
            adel_q    <= (cnt_d != '0) && head_adel;
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = {addr_q[31:2],
                             ADEL_EN ? addr_q[1:0] : 2'b00};
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = valid_q;
`ifdef FETCH_ADEL_EN
    assign bus.inst_adel  = adel_q;
`else
    logic unused_adel;
    assign unused_adel = adel_q;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic
// checked against an in-order instruction stream model.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] KEY      = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    // memory model
    int          lat = 0;
    bit          rand_lat = 0;
    int          wcnt = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] acks [$];
    int          n_req = 0;

    // stream model
    logic [31:0] exp_pc = RESET_PC;
    bit          halted = 0;
    bit          flush_chk = 0;
    int          n_pop = 0;
    int          n_adel = 0;
    logic [31:0] first_pc = '0;
    bit          first_set = 0;

    // per-cycle samples
    logic        s_req, s_valid;
    logic [31:0] s_addr;
    bit          did_ack, did_pop;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
    endtask

    function automatic logic [31:0] ack_at(input int i);
        if (i < acks.size())
            return acks[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic accept();
        logic adel;
`ifdef FETCH_ADEL_EN
        adel = (exp_pc[1:0] != 2'b00);
        check("pop_adel", 32'(bus.inst_adel), 32'(adel));
`else
        adel = 1'b0;
`endif
        check("pop_pc", bus.inst_pc, exp_pc);
        check("pop_inst", bus.inst,
              adel ? 32'h0 : (exp_pc ^ KEY));
        if (!first_set) begin
            first_pc  = bus.inst_pc;
            first_set = 1;
        end
        n_pop++;
        if (adel) begin
            halted = 1;
            n_adel++;
        end else begin
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic tick(input bit rdy, input bit rdr,
                        input logic [31:0] rpc);
        @(negedge clk);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.inst_valid;
        if (flush_chk) begin
            check("flush_empty", 32'(s_valid), 32'd0);
            flush_chk = 0;
        end
        if (halted)
            check("halt_idle", 32'(s_valid | s_req), 32'd0);
        if (!s_valid)
            check("empty_zero", bus.inst | bus.inst_pc, 32'd0);
        if (s_req)
            check("addr_align", 32'(s_addr[1:0]), 32'd0);
        if (s_req && pend)
            check("addr_hold", s_addr, pend_addr);
        if (s_req && !pend) begin
            wcnt = 0;
            if (rand_lat)
                lat = $urandom_range(0, 3);
        end
        did_ack = 0;
        if (s_req) begin
            n_req++;
            if (wcnt >= lat) begin
                did_ack = 1;
                acks.push_back(s_addr);
            end else begin
                wcnt++;
            end
        end
        pend      = s_req && !did_ack;
        pend_addr = s_addr;
        bus.imem_ack   = did_ack;
        bus.imem_rdata = did_ack ? (s_addr ^ KEY) : $urandom;
        bus.inst_ready = rdy;
        did_pop = s_valid && rdy;
        if (did_pop)
            accept();
        redirect    = rdr;
        redirect_pc = rpc;
        if (rdr) begin
`ifdef FETCH_ADEL_EN
            exp_pc = rpc;
`else
            exp_pc = {rpc[31:2], 2'b00};
`endif
            halted    = 0;
            flush_chk = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
`ifdef FETCH_ADEL_EN
        check("rst_adel", 32'(bus.inst_adel), 32'd0);
`endif
        lat       = 0;
        rand_lat  = 0;
        wcnt      = 0;
        pend      = 0;
        acks.delete();
        n_req     = 0;
        exp_pc    = RESET_PC;
        halted    = 0;
        flush_chk = 0;
        n_pop     = 0;
        n_adel    = 0;
        first_set = 0;
        first_pc  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int n0;
        logic [31:0] rpc;

        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;

        // zero-wait streaming after reset
        do_reset();
        tick(1, 0, '0);
        check("c1_req", 32'(s_req), 32'd1);
        check("c1_valid", 32'(s_valid), 32'd0);
        tick(1, 0, '0);
        check("c2_valid", 32'(s_valid), 32'd1);
        repeat (6) tick(1, 0, '0);
        check("stream_pops", n_pop, 7);
        for (int i = 0; i < 4; i++)
            check("stream_addr", ack_at(i),
                  RESET_PC + 32'(4 * i));

        // decode stalled: buffer fills to depth
        do_reset();
        repeat (6) tick(0, 0, '0);
        check("full_req", 32'(s_req), 32'd0);
        check("full_valid", 32'(s_valid), 32'd1);
        check("full_head", bus.inst_pc, RESET_PC);
        check("full_acks", acks.size(), 2);
        repeat (6) tick(1, 0, '0);
        check("drain_pops", n_pop, 6);

        // slow memory, redirect while fetch outstanding
        do_reset();
        lat = 3;
        tick(1, 0, '0);
        check("slow_req", 32'(s_req), 32'd1);
        tick(1, 1, 32'h8000_0100);
        repeat (12) tick(1, 0, '0);
        check("drop_ack0", ack_at(0), RESET_PC);
        check("drop_ack1", ack_at(1), 32'h8000_0100);
        check("drop_first", first_pc, 32'h8000_0100);

        // redirect together with ack and pop
        do_reset();
        repeat (4) tick(1, 0, '0);
        tick(1, 1, 32'h8000_0200);
        check("ack_pop", 32'({did_ack, did_pop}), 32'd3);
        tick(1, 0, '0);
        check("redir_req", 32'(s_req), 32'd1);
        check("redir_addr", s_addr, 32'h8000_0200);
        repeat (4) tick(1, 0, '0);

        // address wrap at top of space
        tick(1, 1, 32'hFFFF_FFFC);
        k = acks.size();
        repeat (4) tick(1, 0, '0);
        check("wrap_a0", ack_at(k), 32'hFFFF_FFFC);
        check("wrap_a1", ack_at(k + 1), 32'h0000_0000);

`ifdef FETCH_ADEL_EN
        // misaligned redirect yields one fault entry
        tick(1, 1, 32'h8000_0002);
        n0 = n_req;
        repeat (6) tick(1, 0, '0);
        check("adel_noreq", n_req - n0, 0);
        check("adel_count", n_adel, 1);
        tick(1, 1, 32'h8000_0000);
        k = acks.size();
        repeat (3) tick(1, 0, '0);
        check("adel_resume", ack_at(k), 32'h8000_0000);
`endif

        // random traffic against the stream model
        do_reset();
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom & 32'hFFFF_FFF0;
            if ($urandom_range(0, 7) == 0)
                rpc = 32'hFFFF_FFF4;
`ifdef FETCH_ADEL_EN
            if ($urandom_range(0, 3) == 0)
                rpc[1:0] = 2'($urandom_range(1, 3));
`else
            rpc[1:0] = 2'($urandom_range(0, 3));
`endif
            tick($urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, rpc);
        end
        check("rand_progress", 32'(n_pop > 500), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
